// File: rtl/card_lock_pkg.sv
// Shared definitions for the card lock: frame geometry, card types and the
// frame reader's state encoding.
package card_lock_pkg;

    localparam int FRAME_BITS = 20;
    localparam int CODE_W     = 16;

    localparam logic [1:0] GUEST       = 2'b00;
    localparam logic [1:0] MAID        = 2'b01;
    localparam logic [1:0] GUEST_RESET = 2'b10;
    localparam logic [1:0] MAID_RESET  = 2'b11;

    localparam logic [CODE_W-1:0] RESET_CODE = 16'hABCD;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SHIFT       = 3'd1,
        ST_CHECK       = 3'd2,
        ST_LOAD        = 3'd3,
        ST_PRESENT     = 3'd4,
        ST_ERROR       = 3'd5,
        ST_WAIT_REMOVE = 3'd6
    } card_state_e;

endpackage

// File: rtl/card_bit_timer.sv
// Idle-cycle counter between bit strobes; flags when TIMEOUT cycles have
// passed without a clear.
module card_bit_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_timeout) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The current idle cycle is the TIMEOUT-th one once TIMEOUT-1 have elapsed.
    assign o_timeout = i_enable && !i_clear && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/card_frame_reader.sv
// Deserialises and validates card-swipe frames, presenting the accepted code
// and type with a clean card_read pulse for the lock stage.
module card_frame_reader
    import card_lock_pkg::*;
#(
    parameter int READ_HOLD = 4,
    parameter int TIMEOUT   = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              card_present,
    input  logic              card_bit,
    input  logic              card_strobe,
    output logic [CODE_W-1:0] entry_code_on_card,
    output logic [1:0]        card_type,
    output logic              card_read,
    output logic              frame_error,
    output logic              busy
);

    localparam int CNT_W  = $clog2(FRAME_BITS + 1);
    localparam int HOLD_W = $clog2(READ_HOLD + 1);
    localparam int DATA_W = FRAME_BITS - 2;

    card_state_e       r_state;
    card_state_e       w_next_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_parity;
    logic [HOLD_W-1:0] r_hold;
    logic              w_timeout;
    logic              w_start;
    logic              w_take_bit;
    logic              w_last_bit;

    card_bit_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   ((r_state != ST_SHIFT) || card_strobe),
        .i_enable  (r_state == ST_SHIFT),
        .o_timeout (w_timeout)
    );

    assign w_start    = (r_state == ST_IDLE) && card_strobe && card_present && card_bit;
    // A strobe coinciding with card removal is dropped: the abort wins.
    assign w_take_bit = (r_state == ST_SHIFT) && card_strobe && card_present;
    assign w_last_bit = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));

    // NOTE: next-state is assigned a default before the case so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (card_strobe && card_present)
                    w_next_state = card_bit ? ST_SHIFT : ST_ERROR;
            end
            ST_SHIFT: begin
                if (!card_present)
                    w_next_state = ST_ERROR;
                else if (card_strobe && w_last_bit)
                    w_next_state = ST_CHECK;
                else if (w_timeout)
                    w_next_state = ST_ERROR;
            end
            ST_CHECK:       w_next_state = r_parity ? ST_ERROR : ST_LOAD;
            ST_LOAD:        w_next_state = ST_PRESENT;
            ST_PRESENT: begin
                if (r_hold == HOLD_W'(READ_HOLD - 1))
                    w_next_state = ST_WAIT_REMOVE;
            end
            ST_ERROR:       w_next_state = ST_WAIT_REMOVE;
            ST_WAIT_REMOVE: begin
                if (!card_present)
                    w_next_state = ST_IDLE;
            end
            default:        w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_bit_cnt          <= '0;
            r_shift            <= '0;
            r_parity           <= 1'b0;
            r_hold             <= '0;
            entry_code_on_card <= '0;
            card_type          <= '0;
            card_read          <= 1'b0;
            frame_error        <= 1'b0;
            busy               <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            busy        <= (w_next_state != ST_IDLE);
            frame_error <= (w_next_state == ST_ERROR);
            // Delayed by one cycle from PRESENT so the code is set up first.
            card_read   <= (r_state == ST_PRESENT);
            r_hold      <= (r_state == ST_PRESENT) ? r_hold + 1'b1 : '0;

            if (w_start) begin
                r_bit_cnt <= CNT_W'(1);
                r_parity  <= 1'b0;
            end else if (w_take_bit) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_parity  <= r_parity ^ card_bit;
                if (!w_last_bit)
                    r_shift <= {r_shift[DATA_W-2:0], card_bit};
            end

            if (r_state == ST_LOAD) begin
                card_type          <= r_shift[DATA_W-1:CODE_W];
                entry_code_on_card <= r_shift[CODE_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_card_frame_reader.sv
// Self-checking bench for card_frame_reader: directed cases plus random frames
// scored against a frame-level model of acceptance, timing and held outputs.
module tb_card_frame_reader;
    import card_lock_pkg::*;

    localparam int READ_HOLD = 4;
    localparam int TIMEOUT   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              card_present;
    logic              card_bit;
    logic              card_strobe;
    logic [CODE_W-1:0] entry_code_on_card;
    logic [1:0]        card_type;
    logic              card_read;
    logic              frame_error;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int err_cnt, err_cyc, read_cnt, read_rise;
    logic prev_read = 1'b0;

    logic [CODE_W-1:0] exp_code = '0;
    logic [1:0]        exp_type = '0;

    always #5 clk = ~clk;

    card_frame_reader #(
        .READ_HOLD (READ_HOLD),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .card_present       (card_present),
        .card_bit           (card_bit),
        .card_strobe        (card_strobe),
        .entry_code_on_card (entry_code_on_card),
        .card_type          (card_type),
        .card_read          (card_read),
        .frame_error        (frame_error),
        .busy               (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and log output pulses; cyc names the cycle now visible.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (frame_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (card_read) begin
            read_cnt++;
            if (!prev_read) read_rise = cyc;
        end
        prev_read = card_read;
    endtask

    task automatic clear_log();
        err_cnt   = 0;
        err_cyc   = -1;
        read_cnt  = 0;
        read_rise = -1;
    endtask

    task automatic send_bit(input logic b);
        card_bit    = b;
        card_strobe = 1'b1;
        step();
        card_strobe = 1'b0;
    endtask

    function automatic logic [19:0] make_frame(input logic [1:0] t, input logic [15:0] c, input logic p);
        return {1'b1, t, c, p};
    endfunction

    // Parity bit that makes the total count of ones over type+code+parity even.
    function automatic logic good_par(input logic [1:0] t, input logic [15:0] c);
        return logic'($countones({t, c}) % 2);
    endfunction

    task automatic insert_card();
        card_strobe  = 1'b0;
        card_present = 1'b0;
        repeat (2) step();
        card_present = 1'b1;
        step();
        clear_log();
    endtask

    task automatic send_frame(input logic [19:0] f, output int n_start, output int n_last);
        n_start = cyc;
        n_last  = cyc;
        for (int i = 19; i >= 0; i--) begin
            n_last = cyc;
            send_bit(f[i]);
            if (i > 0) repeat ($urandom_range(0, 3)) step();
        end
    endtask

    task automatic run_frame(input logic [19:0] f, input string name);
        int n_start, n_last, rc, ec;
        logic ok;
        logic [CODE_W-1:0] old_code, new_code;
        logic [1:0] old_type, new_type;

        insert_card();
        check({name, "_idle_busy"}, busy, 0);
        ok       = f[19] && ($countones(f[18:0]) % 2 == 0);
        old_code = exp_code;
        old_type = exp_type;
        new_code = ok ? f[16:1] : old_code;
        new_type = ok ? f[18:17] : old_type;

        send_frame(f, n_start, n_last);
        while (cyc < n_last + 10) begin
            step();
            if (cyc == n_last + 2) check({name, "_code_before"}, entry_code_on_card, old_code);
            if (cyc == n_last + 3) begin
                check({name, "_code"}, entry_code_on_card, new_code);
                check({name, "_type"}, card_type, new_type);
            end
        end
        exp_code = new_code;
        exp_type = new_type;

        check({name, "_read_cycles"}, read_cnt, ok ? READ_HOLD : 0);
        if (ok) check({name, "_read_rise"}, read_rise, n_last + 4);
        check({name, "_err_pulses"}, err_cnt, ok ? 0 : 1);
        if (!ok) check({name, "_err_cycle"}, err_cyc, f[19] ? n_last + 2 : n_start + 1);
        check({name, "_busy_held"}, busy, 1);

        rc = read_cnt;
        ec = err_cnt;
        repeat (3) begin
            send_bit(1'($urandom_range(0, 1)));
            step();
        end
        check({name, "_no_reread"}, read_cnt, rc);
        check({name, "_no_reerr"}, err_cnt, ec);
        check({name, "_code_kept"}, entry_code_on_card, exp_code);

        card_present = 1'b0;
        repeat (2) step();
        check({name, "_busy_off"}, busy, 0);
    endtask

    initial begin
        logic [19:0] f;
        logic [1:0]  t;
        logic [15:0] c;
        logic        p;
        int          n_start, n_last, n_ab;

        reset        = 1'b1;
        card_present = 1'b0;
        card_bit     = 1'b0;
        card_strobe  = 1'b0;
        clear_log();
        repeat (2) step();
        check("rst_code", entry_code_on_card, 0);
        check("rst_type", card_type, 0);
        check("rst_read", card_read, 0);
        check("rst_err", frame_error, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        step();

        run_frame(make_frame(GUEST, 16'h1234, 1'b1), "guest");
        run_frame(make_frame(GUEST_RESET, RESET_CODE, 1'b1), "greset");
        run_frame(make_frame(GUEST, 16'h1234, 1'b0), "badpar");
        f = make_frame(MAID, 16'h1111, good_par(MAID, 16'h1111));
        f[19] = 1'b0;
        run_frame(f, "start0");

        // Timeout: 10 bits, then silence.
        insert_card();
        f = make_frame(MAID_RESET, 16'hBEEF, good_par(MAID_RESET, 16'hBEEF));
        n_last = cyc;
        for (int i = 19; i >= 10; i--) begin
            n_last = cyc;
            send_bit(f[i]);
        end
        repeat (TIMEOUT + 8) step();
        check("tmo_err_cycle", err_cyc, n_last + TIMEOUT + 1);
        check("tmo_err_pulses", err_cnt, 1);
        check("tmo_no_read", read_cnt, 0);
        check("tmo_code_kept", entry_code_on_card, exp_code);
        check("tmo_type_kept", card_type, exp_type);

        // Abort: removal together with a strobe after 7 bits.
        insert_card();
        for (int i = 19; i >= 13; i--) send_bit(f[i]);
        n_ab         = cyc;
        card_bit     = 1'b1;
        card_strobe  = 1'b1;
        card_present = 1'b0;
        step();
        card_strobe = 1'b0;
        repeat (5) step();
        check("abort_err_cycle", err_cyc, n_ab + 1);
        check("abort_err_pulses", err_cnt, 1);
        check("abort_no_read", read_cnt, 0);
        check("abort_code_kept", entry_code_on_card, exp_code);
        check("abort_busy_off", busy, 0);

        // Reset while the read pulse is active.
        insert_card();
        send_frame(make_frame(GUEST, 16'h5A5A, good_par(GUEST, 16'h5A5A)), n_start, n_last);
        while (cyc < n_last + 5) step();
        check("prst_read_high", card_read, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("prst_read", card_read, 0);
        check("prst_busy", busy, 0);
        check("prst_code", entry_code_on_card, 0);
        check("prst_type", card_type, 0);
        exp_code = '0;
        exp_type = '0;
        run_frame(make_frame(MAID, 16'h0001, 1'b0), "maid");

        for (int k = 0; k < 10; k++) begin
            t = 2'($urandom_range(0, 3));
            c = 16'($urandom);
            p = good_par(t, c);
            if ($urandom_range(0, 3) == 0) p = ~p;
            f = make_frame(t, c, p);
            if ($urandom_range(0, 7) == 0) f[19] = 1'b0;
            run_frame(f, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/card_frame_reader.md
# card_frame_reader

Upstream front end of the electronic card lock. Deserialises the bit stream from the card-swipe head, checks framing and parity, and presents `entry_code_on_card`, `card_type` and a clean `card_read` pulse to the lock stage. The lock latches on the rising edge of `card_read`, so this block guarantees the code and type are stable before that edge and for the whole pulse.

## Interface
- `READ_HOLD`, default 4: cycles `card_read` stays high per accepted frame (≥1).
- `TIMEOUT`, default 1000: maximum idle cycles between bit strobes inside a frame (≥2).
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `card_present` input 1: head detects a card; level.
- `card_bit` input 1: serial data; sampled only when `card_strobe`=1.
- `card_strobe` input 1: one-cycle bit-valid pulse.
- `entry_code_on_card` output 16: last accepted code.
- `card_type` output 2: last accepted type.
- `card_read` output 1: READ_HOLD-cycle pulse per accepted frame.
- `frame_error` output 1: one-cycle pulse on rejected frame.
- `busy` output 1: high in every state except IDLE.

## Operation
- Frame is 20 bits, first bit first: start bit (must be 1), `card_type[1:0]` MSB first, code[15:0] MSB first, parity bit.
- Parity is even over the 18 type+code bits plus the parity bit; the total count of ones must be even.
- FSM states:
  - IDLE → SHIFT on a strobe with `card_present`=1 (that strobe is the start bit).
  - In IDLE, a start bit of 0 → ERROR.
  - SHIFT → CHECK when the 20th bit is sampled.
  - CHECK → LOAD if parity is good, else ERROR.
  - LOAD → PRESENT.
  - PRESENT → WAIT_REMOVE after READ_HOLD cycles.
  - ERROR → WAIT_REMOVE after 1 cycle.
  - WAIT_REMOVE → IDLE when `card_present`=0.
- In SHIFT:
  - `card_present` falling → ERROR (abort).
  - Idle counter reaching TIMEOUT with no strobe → ERROR.
  - The counter clears on every strobe.
- Strobes are ignored in CHECK, LOAD, PRESENT, ERROR and WAIT_REMOVE. One read per insertion.
- Outputs hold the last good frame. Rejected frames never modify `entry_code_on_card` or `card_type`.
- Simultaneous strobe and `card_present` fall in SHIFT: the abort wins and the bit is discarded.
- Reset mid-frame discards the partial frame. If `card_read` is high, it drops in the next cycle.

## Timing
- All outputs are registered. Reset values:
  - `entry_code_on_card`=16'h0
  - `card_type`=2'b00
  - `card_read`=0
  - `frame_error`=0
  - `busy`=0
  - state=IDLE, bit count=0, idle counter=0
- Parity bit sampled in cycle N: CHECK in N+1, LOAD in N+2.
- New code and type are visible from N+3. `card_read` rises at N+4 (one cycle of setup) and is high for exactly READ_HOLD cycles.
- Bad parity: `frame_error` high in cycle N+2 only.
- Timeout: ERROR is entered TIMEOUT cycles after the last strobe. `frame_error` is high the cycle after that.
- `busy` rises the cycle after the start strobe and falls the cycle after entering IDLE.

## Structure
- Shared package `card_lock_pkg` holds:
  - FSM state enum.
  - `FRAME_BITS`=20, `CODE_W`=16.
  - Card-type constants: GUEST=2'b00, MAID=2'b01, GUEST_RESET=2'b10, MAID_RESET=2'b11.
  - `RESET_CODE`=16'hABCD.
- One sub-module, `card_bit_timer`: idle counter with clear/enable and a `timeout` flag, parameterised by TIMEOUT.
- The shift register, parity accumulator and FSM stay in `card_frame_reader`.

## Test plan
- Guest card, code 16'h1234, type 00, parity 1 -> `entry_code_on_card`=16'h1234 and `card_type`=00 from N+3; `card_read` high N+4..N+7; `frame_error`=0.
- Guest-reset card, code 16'hABCD, type 10, parity 1 -> outputs 16'hABCD/10; one `card_read` pulse. Further strobes before `card_present` drops produce no second pulse.
- Same 16'h1234 frame with parity 0 -> `frame_error` pulse at N+2; outputs keep previous values; `card_read` stays 0.
- Start bit 0 -> immediate ERROR and `frame_error` pulse. Frame data is ignored until `card_present` has been removed and reinserted.
- Stop strobing after 10 bits with TIMEOUT=8 -> `frame_error` 9 cycles after the last strobe. Also drop `card_present` mid-frame -> abort. Outputs unchanged in both cases.
- Assert `reset` during PRESENT -> `card_read`, `busy` and the outputs are 0 the next cycle. A following valid maid frame (type 01, code 16'h0001, parity 0) is accepted normally.
